// File: rtl/twos_to_sign_mag_serial_if.sv
// Handshake bundle for the serial two's-complement to sign-magnitude converter.
// min_neg exists only when TWOS_DEC_MINNEG_EN is defined.
interface twos_to_sign_mag_serial_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
`ifdef TWOS_DEC_MINNEG_EN
    logic             min_neg;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_mag, min_neg
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_mag, min_neg
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_mag
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_mag
    );
`endif
endinterface

// File: rtl/twos_to_sign_mag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, one bit per clock.
// Optional min_neg flag (most-negative input) enabled by defining TWOS_DEC_MINNEG_EN.
module twos_to_sign_mag_serial #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    twos_to_sign_mag_serial_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_mag;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;
    logic             r_seen_one;
    logic             w_bit;
    logic             w_out_bit;
    logic             w_last;

    assign w_bit     = r_sreg[0];
    // Copy up to and including the first 1, invert everything after it.
    assign w_out_bit = (r_sign && r_seen_one) ? ~w_bit : w_bit;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sreg     <= '0;
            r_mag      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_seen_one <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sreg     <= bus.in_data;
                        r_sign     <= bus.in_data[WIDTH-1];
                        r_seen_one <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sreg     <= r_sreg >> 1;
                    r_mag      <= {w_out_bit, r_mag[WIDTH-1:1]};
                    r_seen_one <= r_seen_one | w_bit;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TWOS_DEC_MINNEG_EN
    logic r_min_neg;

    // At the last shift seen_one still covers only bits 0..WIDTH-2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min_neg <= 1'b0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_min_neg <= 1'b0;
        end else if (r_state == S_SHIFT && w_last) begin
            r_min_neg <= r_sign && !r_seen_one;
        end
    end

    assign bus.min_neg = r_min_neg;
`endif

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_sign  = r_sign;
    assign bus.out_mag   = r_mag;
endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
// Scoreboard bench for twos_to_sign_mag_serial at WIDTH=4.
module tb_twos_to_sign_mag_serial;
    localparam int W = 4;

    typedef struct packed {
        logic         sign;
        logic [W-1:0] mag;
        logic         mn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;
    exp_t sb[$];

    twos_to_sign_mag_serial_if #(.WIDTH(W)) bus ();

    twos_to_sign_mag_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] d);
        exp_t r;
        int   v;
        v      = int'($signed(d));
        r.sign = (v < 0);
        r.mag  = W'((v < 0) ? -v : v);
        r.mn   = (v == -(1 << (W - 1)));
        return r;
    endfunction

    // Handshake one word and push its expected result; called 1ns after a rising edge.
    task automatic drive_word(input logic [W-1:0] d, output bit ok, output int hs_cyc);
        int n;
        n  = 0;
        ok = 1'b0;
        hs_cyc = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (bus.in_ready) begin
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            hs_cyc = cyc_cnt;
            sb.push_back(model(d));
            ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sign !== 1'b0 || bus.out_mag !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sign=%b mag=%b, required 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.out_sign, bus.out_mag);
        end
`ifdef TWOS_DEC_MINNEG_EN
        n_vec++;
        if (bus.min_neg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_min_neg: got %b, required 0", bus.min_neg);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset released: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    endtask

    task automatic test_basic();
        bit   ok;
        int   hs, lat;
        exp_t e;
        bus.out_ready = 1'b1;
        drive_word(4'b0101, ok, hs);
        wait_valid(lat);
        n_vec++;
        if (!ok || lat != W) begin
            n_err++;
            $display("FAIL basic_latency: got ok=%0d latency=%0d edges, required 1 and %0d", ok, lat, W);
        end
        e = sb.pop_front();
        n_vec++;
        if (bus.out_sign !== e.sign || bus.out_mag !== e.mag) begin
            n_err++;
            $display("FAIL basic_result: got sign=%b mag=%b, required sign=%b mag=%b",
                     bus.out_sign, bus.out_mag, e.sign, e.mag);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_one_cycle_valid: got rdy=%b vld=%b, required 1 0", bus.in_ready, bus.out_valid);
        end
        $display("basic 0101 -> sign=%b mag=%b latency=%0d", e.sign, e.mag, lat);
    endtask

    task automatic test_values();
        logic [W-1:0] tbl [5];
        bit   ok;
        int   hs, lat;
        exp_t e;
        tbl = '{4'b1011, 4'b1111, 4'b0000, 4'b1000, 4'b1001};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_word(tbl[i], ok, hs);
            wait_valid(lat);
            e = sb.pop_front();
            n_vec++;
            if (!ok || !bus.out_valid || bus.out_sign !== e.sign || bus.out_mag !== e.mag) begin
                n_err++;
                $display("FAIL values_%b: got vld=%b sign=%b mag=%b, required vld=1 sign=%b mag=%b",
                         tbl[i], bus.out_valid, bus.out_sign, bus.out_mag, e.sign, e.mag);
            end
`ifdef TWOS_DEC_MINNEG_EN
            n_vec++;
            if (bus.min_neg !== e.mn) begin
                n_err++;
                $display("FAIL min_neg_%b: got %b, required %b", tbl[i], bus.min_neg, e.mn);
            end
`endif
            $display("value %b -> sign=%b mag=%b", tbl[i], bus.out_sign, bus.out_mag);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   hs, lat;
        exp_t e;
        bus.out_ready = 1'b0;
        drive_word(4'b1110, ok, hs);
        wait_valid(lat);
        e = sb.pop_front();
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (!ok || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_sign !== e.sign || bus.out_mag !== e.mag) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b sign=%b mag=%b, required 1 0 %b %b",
                         i, bus.out_valid, bus.in_ready, bus.out_sign, bus.out_mag, e.sign, e.mag);
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_no_capture: got rdy=%b vld=%b, required 1 0", bus.in_ready, bus.out_valid);
        end
        $display("backpressure 1110 -> sign=%b mag=%b held 3 cycles", e.sign, e.mag);
    endtask

    task automatic test_reset_midshift();
        bit   ok;
        int   hs, lat;
        exp_t e;
        bit   seen;
        bus.out_ready = 1'b1;
        drive_word(4'b1100, ok, hs);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sign !== 1'b0 || bus.out_mag !== '0) begin
            n_err++;
            $display("FAIL midshift_reset_outputs: got rdy=%b vld=%b sign=%b mag=%b, required 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.out_sign, bus.out_mag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        seen = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++;
        if (seen || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midshift_discard: got out_valid_seen=%0d rdy=%b, required 0 1", seen, bus.in_ready);
        end
        drive_word(4'b0011, ok, hs);
        wait_valid(lat);
        e = sb.pop_front();
        n_vec++;
        if (!ok || lat != W || bus.out_sign !== e.sign || bus.out_mag !== e.mag) begin
            n_err++;
            $display("FAIL after_reset_word: got lat=%0d sign=%b mag=%b, required %0d %b %b",
                     lat, bus.out_sign, bus.out_mag, W, e.sign, e.mag);
        end
        $display("reset mid-shift, next word 0011 -> sign=%b mag=%b", bus.out_sign, bus.out_mag);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit   ok;
        int   hs, prev_hs, lat, n;
        exp_t e;
        bit   taken;
        prev_hs = -100;
        for (int v = 0; v < 16; v++) begin
            drive_word(W'(v), ok, hs);
            if (prev_hs >= 0) begin
                n_vec++;
                if (hs - prev_hs < W + 2) begin
                    n_err++;
                    $display("FAIL ii_%0d: got interval %0d, required >= %0d", v, hs - prev_hs, W + 2);
                end
            end
            prev_hs = hs;
            wait_valid(lat);
            e = sb.pop_front();
            taken = 1'b0;
            n = 0;
            while (!taken) begin
                n_vec++;
                if (!ok || bus.out_valid !== 1'b1 || bus.out_sign !== e.sign || bus.out_mag !== e.mag) begin
                    n_err++;
                    $display("FAIL b2b_%0d: got vld=%b sign=%b mag=%b, required 1 %b %b",
                             v, bus.out_valid, bus.out_sign, bus.out_mag, e.sign, e.mag);
                end
                bus.out_ready = (n >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
                taken = bus.out_ready;
                @(posedge clk); #1;
                n++;
            end
            $display("b2b %b -> sign=%b mag=%b stalls=%0d", 4'(v), e.sign, e.mag, n - 1);
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_reset_midshift();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
